// File: rtl/instr_pkg.sv
// Shared payload types for the host <-> NMCU instruction/response link.
package instr_pkg;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  tag;
        logic [15:0] operand;
    } instruction_t;

    typedef struct packed {
        logic [7:0]  tag;
        logic [15:0] data;
        logic        status;
    } nmcu_cpu_resp_t;

endpackage

// File: rtl/nmcu_host_issuer_if.sv
// Host/NMCU side signals of the host issuer; master is the issuer, slave its environment.
interface nmcu_host_issuer_if #(
    parameter int unsigned MAX_OUTSTANDING = 2
);
    import instr_pkg::*;

    logic                                 host_cmd_valid_i;
    instruction_t                         host_cmd_i;
    logic                                 host_cmd_ready_o;
    logic                                 cpu_instr_valid_o;
    instruction_t                         cpu_instruction_o;
    logic                                 cpu_instr_ready_i;
    logic                                 nmcu_resp_valid_i;
    nmcu_cpu_resp_t                       nmcu_response_i;
    logic                                 nmcu_resp_ready_o;
    logic                                 host_rsp_valid_o;
    nmcu_cpu_resp_t                       host_rsp_o;
    logic                                 host_rsp_ready_i;
    logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o;
    logic                                 timeout_err_o;
    logic                                 spurious_err_o;
    logic                                 clear_err_i;
    logic                                 idle_o;

    modport master (
        input  host_cmd_valid_i, host_cmd_i, cpu_instr_ready_i,
               nmcu_resp_valid_i, nmcu_response_i, host_rsp_ready_i, clear_err_i,
        output host_cmd_ready_o, cpu_instr_valid_o, cpu_instruction_o,
               nmcu_resp_ready_o, host_rsp_valid_o, host_rsp_o,
               outstanding_o, timeout_err_o, spurious_err_o, idle_o
    );

    modport slave (
        output host_cmd_valid_i, host_cmd_i, cpu_instr_ready_i,
               nmcu_resp_valid_i, nmcu_response_i, host_rsp_ready_i, clear_err_i,
        input  host_cmd_ready_o, cpu_instr_valid_o, cpu_instruction_o,
               nmcu_resp_ready_o, host_rsp_valid_o, host_rsp_o,
               outstanding_o, timeout_err_o, spurious_err_o, idle_o
    );

endinterface

// File: rtl/nmcu_host_issuer.sv
// Host-side NMCU initiator: command FIFO, credit-gated issue, response FIFO and
// a watchdog that trips when outstanding instructions stop being answered.
module nmcu_host_issuer #(
    parameter int unsigned CMD_DEPTH       = 4,
    parameter int unsigned RSP_DEPTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic               clk,
    input  logic               rst,
    nmcu_host_issuer_if.master bus
);
    import instr_pkg::*;

    localparam int unsigned CPW = $clog2(CMD_DEPTH);
    localparam int unsigned CCW = $clog2(CMD_DEPTH + 1);
    localparam int unsigned RPW = $clog2(RSP_DEPTH);
    localparam int unsigned RCW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES);

    localparam logic [WDW-1:0] WD_TRIP = WDW'(TIMEOUT_CYCLES - 2);
    localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {ST_RUN, ST_ERR} state_t;

    state_t         state, state_next;

    instruction_t   cmd_mem [CMD_DEPTH];
    logic [CPW-1:0] cmd_wr_ptr, cmd_rd_ptr;
    logic [CCW-1:0] cmd_count, cmd_count_next;

    nmcu_cpu_resp_t rsp_mem [RSP_DEPTH];
    logic [RPW-1:0] rsp_wr_ptr, rsp_rd_ptr;
    logic [RCW-1:0] rsp_count, rsp_count_next;

    logic [OW-1:0]  outstanding, outstanding_next;
    logic [WDW-1:0] wd_count, wd_next;

    logic           instr_valid, instr_valid_next;
    logic           rsp_valid, rsp_valid_next;
    logic           timeout_err, spurious_err;
    logic           timeout_trip;
    logic           cmd_full, rsp_full;
    logic           cmd_push, issue_fire, rsp_push, rsp_pop, spurious;
    logic           cmd_avail;
    logic [31:0]    credit_sum;

    assign cmd_full   = (cmd_count == CCW'(CMD_DEPTH));
    assign rsp_full   = (rsp_count == RCW'(RSP_DEPTH));
    assign cmd_push   = bus.host_cmd_valid_i & ~cmd_full;
    assign issue_fire = instr_valid & bus.cpu_instr_ready_i;
    assign rsp_push   = bus.nmcu_resp_valid_i & ~rsp_full;
    assign rsp_pop    = rsp_valid & bus.host_rsp_ready_i;
    assign spurious   = rsp_push & (outstanding == '0);

    always_comb begin
        cmd_count_next = cmd_count + CCW'(cmd_push) - CCW'(issue_fire);
        rsp_count_next = rsp_count + RCW'(rsp_push) - RCW'(rsp_pop);

        // An instruction issued this cycle cannot be answered this cycle, so a
        // response seen with zero credits in use never consumes the new credit.
        outstanding_next = outstanding;
        if (spurious)
            outstanding_next = outstanding + OW'(issue_fire);
        else if (issue_fire & ~rsp_push)
            outstanding_next = outstanding + OW'(1);
        else if (~issue_fire & rsp_push)
            outstanding_next = outstanding - OW'(1);

        wd_next      = wd_count;
        timeout_trip = 1'b0;
        if (bus.clear_err_i | rsp_push | (outstanding == '0)) begin
            wd_next = '0;
        end else begin
            if (wd_count != WD_MAX)
                wd_next = wd_count + WDW'(1);
            timeout_trip = (state == ST_RUN) & (wd_count == WD_TRIP);
        end

        state_next = state;
        if (bus.clear_err_i)
            state_next = ST_RUN;
        else if (timeout_trip)
            state_next = ST_ERR;

        // Commands pushed this cycle are excluded so the head is never bypassed.
        cmd_avail  = (cmd_count != CCW'(issue_fire));
        credit_sum = 32'(outstanding_next) + 32'(rsp_count_next);

        instr_valid_next = (instr_valid & ~bus.cpu_instr_ready_i) |
                           (cmd_avail & (state_next == ST_RUN) &
                            (outstanding_next < OW'(MAX_OUTSTANDING)) &
                            (credit_sum < RSP_DEPTH));

        rsp_valid_next = (rsp_count != RCW'(rsp_pop));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            cmd_wr_ptr   <= '0;
            cmd_rd_ptr   <= '0;
            cmd_count    <= '0;
            rsp_wr_ptr   <= '0;
            rsp_rd_ptr   <= '0;
            rsp_count    <= '0;
            outstanding  <= '0;
            wd_count     <= '0;
            instr_valid  <= 1'b0;
            rsp_valid    <= 1'b0;
            timeout_err  <= 1'b0;
            spurious_err <= 1'b0;
        end else begin
            state       <= state_next;
            cmd_count   <= cmd_count_next;
            rsp_count   <= rsp_count_next;
            outstanding <= outstanding_next;
            wd_count    <= wd_next;
            instr_valid <= instr_valid_next;
            rsp_valid   <= rsp_valid_next;

            if (cmd_push)
                cmd_wr_ptr <= cmd_wr_ptr + CPW'(1);
            if (issue_fire)
                cmd_rd_ptr <= cmd_rd_ptr + CPW'(1);
            if (rsp_push)
                rsp_wr_ptr <= rsp_wr_ptr + RPW'(1);
            if (rsp_pop)
                rsp_rd_ptr <= rsp_rd_ptr + RPW'(1);

            if (bus.clear_err_i)
                timeout_err <= 1'b0;
            else if (timeout_trip)
                timeout_err <= 1'b1;

            if (spurious)
                spurious_err <= 1'b1;
            else if (bus.clear_err_i)
                spurious_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_push)
            cmd_mem[cmd_wr_ptr] <= bus.host_cmd_i;
        if (rsp_push)
            rsp_mem[rsp_wr_ptr] <= bus.nmcu_response_i;
    end

    assign bus.host_cmd_ready_o  = ~cmd_full;
    assign bus.cpu_instr_valid_o = instr_valid;
    assign bus.cpu_instruction_o = cmd_mem[cmd_rd_ptr];
    assign bus.nmcu_resp_ready_o = ~rsp_full;
    assign bus.host_rsp_valid_o  = rsp_valid;
    assign bus.host_rsp_o        = rsp_mem[rsp_rd_ptr];
    assign bus.outstanding_o     = outstanding;
    assign bus.timeout_err_o     = timeout_err;
    assign bus.spurious_err_o    = spurious_err;
    assign bus.idle_o            = (cmd_count == '0) & (rsp_count == '0) & (outstanding == '0);

endmodule

// File: doc/nmcu_host_issuer.md
# nmcu_host_issuer

Host-side initiator for the NMCU instruction/response link. Buffers instructions from the host CPU model, issues them to the NMCU `cpu_instr_*` port under a valid/ready handshake, and limits the number of in-flight instructions with credits. It collects `nmcu_resp_*` responses into a return FIFO, and runs a watchdog that flags a stalled NMCU. It sits between the host/interconnect model and the `nmcu` chiplet top.

## Interface
- `CMD_DEPTH`, default 4: command FIFO entries (power of 2, ≥2).
- `RSP_DEPTH`, default 4: response FIFO entries (power of 2, ≥2).
- `MAX_OUTSTANDING`, default 2: maximum issued-but-unanswered instructions (1..RSP_DEPTH).
- `TIMEOUT_CYCLES`, default 1024: cycles with outstanding>0 and no response before the error trips (≥2).

Ports:
- `clk` in 1: single clock, all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `host_cmd_valid_i` in 1: host offers an instruction.
- `host_cmd_i` in `instr_pkg::instruction_t`: instruction payload.
- `host_cmd_ready_o` out 1: command FIFO not full.
- `cpu_instr_valid_o` out 1: instruction offered to NMCU.
- `cpu_instruction_o` out `instr_pkg::instruction_t`: head of command FIFO.
- `cpu_instr_ready_i` in 1: NMCU accepts.
- `nmcu_resp_valid_i` in 1: NMCU response valid.
- `nmcu_response_i` in `instr_pkg::nmcu_cpu_resp_t`: response payload.
- `nmcu_resp_ready_o` out 1: response FIFO not full.
- `host_rsp_valid_o` out 1: response FIFO not empty.
- `host_rsp_o` out `instr_pkg::nmcu_cpu_resp_t`: head of response FIFO.
- `host_rsp_ready_i` in 1: host pops response.
- `outstanding_o` out `$clog2(MAX_OUTSTANDING+1)`: in-flight count.
- `timeout_err_o` out 1: sticky watchdog error.
- `spurious_err_o` out 1: sticky, response received with outstanding==0.
- `clear_err_i` in 1: clears both sticky errors and the watchdog.
- `idle_o` out 1: both FIFOs empty and outstanding==0.

## Operation
- Command FIFO: push on `host_cmd_valid_i & host_cmd_ready_o`. No same-cycle pass-through; a push into an empty FIFO is visible at the head the next cycle. At full, ready=0; a simultaneous pop does not raise ready in the same cycle.
- Issue gate: `cpu_instr_valid_o` = cmd FIFO not empty & state==RUN & outstanding<MAX_OUTSTANDING & (outstanding + rsp_count) < RSP_DEPTH. The last term guarantees every in-flight response has a return slot.
- Once `cpu_instr_valid_o` is asserted, it and `cpu_instruction_o` hold stable until `cpu_instr_ready_i`. The gate is re-evaluated only while valid is low.
- Issue fires on valid&ready: pop cmd FIFO, outstanding+1.
- Response fires on `nmcu_resp_valid_i & nmcu_resp_ready_o`: push rsp FIFO, outstanding−1. If outstanding==0, the count stays 0 and `spurious_err_o` is set; the response is still stored.
- Issue and response in the same cycle: outstanding unchanged.
- Response FIFO: pop on `host_rsp_valid_o & host_rsp_ready_i`. Same no-bypass and full rules as the command FIFO.
- Watchdog counter:
  - Resets to 0 on any response, on `clear_err_i`, and whenever outstanding==0.
  - Otherwise increments while outstanding>0.
  - Reaching TIMEOUT_CYCLES−1 moves the FSM to ERR.
- FSM RUN→ERR: on timeout, set `timeout_err_o`. In ERR, no new issue starts; an already-asserted `cpu_instr_valid_o` still completes its handshake. Responses are still accepted in ERR.
- FSM ERR→RUN: on `clear_err_i`. `clear_err_i` in RUN clears only `spurious_err_o`.

## Timing
- Reset (`rst`=1 at an edge): FIFOs empty, outstanding=0, watchdog=0, FSM=RUN. Reset values: `host_cmd_ready_o`=1, `nmcu_resp_ready_o`=1, `cpu_instr_valid_o`=0, `host_rsp_valid_o`=0, `timeout_err_o`=0, `spurious_err_o`=0, `idle_o`=1, `outstanding_o`=0.
- Reset mid-operation discards buffered commands, responses, and credit state with no further handshakes. Payload outputs are don't-care while valid=0.
- Latency: host push at edge N → `cpu_instr_valid_o` high after edge N+1 (minimum). NMCU response at edge M → `host_rsp_valid_o` high after edge M+1.
- Throughput: one issue per cycle and one response per cycle when ungated.
- All outputs are registered or derived from registered state only (FIFO levels, counters, FSM). There are no combinational paths from `*_ready_i`/`*_valid_i` to any output.

## Test plan
- Reset then push 1 instruction, NMCU ready=1 → valid rises 1 cycle after the push, fires once. outstanding 0→1; NMCU response → outstanding 0; `host_rsp_valid_o` asserts the next cycle with identical payload; `idle_o`=1 after pop.
- Push 4 with MAX_OUTSTANDING=2, no responses → exactly 2 issued, valid held low, outstanding=2. Return 1 response → third issues the next cycle.
- NMCU ready=0 for 5 cycles with valid high → payload and valid stable throughout. Same-cycle issue+response → outstanding unchanged.
- Host ready=0, RSP_DEPTH=4, 6 commands → issue stops once outstanding+rsp_count=4; no response is dropped; draining releases the remainder in order.
- TIMEOUT_CYCLES=8, 1 issued, no response → `timeout_err_o`=1 at the 8th cycle, further issues blocked. A late response is stored; `clear_err_i` resumes issue.
- Response injected with outstanding=0 → `spurious_err_o`=1, outstanding stays 0, response delivered to host.
